// File: rtl/pixel_channel_sequencer_pkg.sv
// Shared types and constants for the pixel channel sequencer and the strength adder it feeds.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a. Optional macro BGR_ORDER_EN selects a B,G,R byte order instead of R,G,B.
package pixel_channel_sequencer_pkg;

  localparam int BYTE_W     = 8;
  localparam int STRENGTH_W = 22;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_e;

`ifdef BGR_ORDER_EN
  // Stream arrives as B,G,R: a pixel starts on B and is complete after R.
  localparam phase_e PH_FIRST = PH_B;
  localparam phase_e PH_LAST  = PH_R;
`else
  // Stream arrives as R,G,B: a pixel starts on R and is complete after B.
  localparam phase_e PH_FIRST = PH_R;
  localparam phase_e PH_LAST  = PH_B;
`endif

  // Channel that follows p in the stream order.
  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    n = PH_FIRST;
`ifdef BGR_ORDER_EN
    case (p)
      PH_B:    n = PH_G;
      PH_G:    n = PH_R;
      default: n = PH_B;
    endcase
`else
    case (p)
      PH_R:    n = PH_G;
      PH_G:    n = PH_B;
      default: n = PH_R;
    endcase
`endif
    return n;
  endfunction

  // Enable vector {R,G,B} for a channel; an illegal code raises nothing.
  function automatic logic [2:0] phase_onehot(input phase_e p);
    logic [2:0] oh;
    oh = 3'b000;
    case (p)
      PH_R:    oh = 3'b100;
      PH_G:    oh = 3'b010;
      PH_B:    oh = 3'b001;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/pixel_channel_sequencer_rgb_phase_ctr.sv
// Mod-3 channel rotator: tracks which colour channel the next accepted byte belongs to.
// Latency: phase updates one cycle after clear_i/advance_i; last_ch_o decodes the current phase.
// Backpressure: none; advance_i is only pulsed for accepted bytes. Honours BGR_ORDER_EN via the package.
module pixel_channel_sequencer_rgb_phase_ctr
  import pixel_channel_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       advance_i,
  output logic [1:0] phase_o,
  output logic       last_ch_o
);

  phase_e phase_q;
  phase_e phase_d;

  // Next phase: clear wins over advance so a restart always begins on the first channel.
  always_comb begin
    phase_d = phase_q;
    if (clear_i) begin
      phase_d = PH_FIRST;
    end else if (advance_i) begin
      phase_d = next_phase(phase_q);
    end
  end

  // Phase register with synchronous reset to the first channel of a pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_FIRST;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o   = phase_q;
  assign last_ch_o = (phase_q == PH_LAST);

endmodule

// File: rtl/pixel_channel_sequencer.sv
// Steers an interleaved channel byte stream onto strength_out with one channel enable, and frames the image.
// Latency: one cycle from an accepted byte to strength_out/enable; frame_done one cycle after the last enable.
// Backpressure: none; bytes outside an active frame are dropped. Optional macro BGR_ORDER_EN selects B,G,R order.
module pixel_channel_sequencer
  import pixel_channel_sequencer_pkg::*;
#(
  parameter int NUM_PIXELS = 16384,
  parameter int CNT_W      = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [BYTE_W-1:0] pixel_in,
  input  logic              pixel_valid,
  output logic [BYTE_W-1:0] strength_out,
  output logic              Radd_en,
  output logic              Gadd_en,
  output logic              Badd_en,
  output logic              acc_clear,
  output logic              busy,
  output logic              frame_done
);

  state_e            state_q;
  logic [CNT_W-1:0]  pixel_cnt_q;
  logic [BYTE_W-1:0] strength_q;
  logic [2:0]        en_q;
  logic              acc_clear_q;
  logic              busy_q;
  logic              frame_done_q;

  logic [1:0]        phase_raw;
  phase_e            cur_phase;
  logic              last_ch;
  logic              accept;
  logic              last_pixel;
  logic              cnt_sat;

  // A byte is taken only inside a frame, and never in a cycle that restarts the frame.
  assign accept     = (state_q == S_ACTIVE) && pixel_valid && !frame_start;
  assign last_pixel = (pixel_cnt_q == CNT_W'(NUM_PIXELS - 1));
  assign cnt_sat    = (pixel_cnt_q == CNT_W'(NUM_PIXELS));
  assign cur_phase  = phase_e'(phase_raw);

  pixel_channel_sequencer_rgb_phase_ctr u_phase_ctr (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (frame_start),
    .advance_i (accept),
    .phase_o   (phase_raw),
    .last_ch_o (last_ch)
  );

  // Frame FSM with registered outputs; frame_start restarts from any state and suppresses frame_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pixel_cnt_q  <= '0;
      strength_q   <= '0;
      en_q         <= 3'b000;
      acc_clear_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // Pulsed outputs default low; strength_q holds between bytes.
      en_q         <= 3'b000;
      acc_clear_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (frame_start) begin
        state_q     <= S_ACTIVE;
        pixel_cnt_q <= '0;
        acc_clear_q <= 1'b1;
        busy_q      <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            busy_q <= 1'b0;
          end
          S_ACTIVE: begin
            if (pixel_valid) begin
              strength_q <= pixel_in;
              en_q       <= phase_onehot(cur_phase);
              if (last_ch) begin
                if (!cnt_sat) begin
                  pixel_cnt_q <= pixel_cnt_q + CNT_W'(1);
                end
                // Last channel of the last pixel: its enable goes out next cycle, then frame_done.
                if (last_pixel) begin
                  state_q <= S_FLUSH;
                end
              end
            end
          end
          S_FLUSH: begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign strength_out = strength_q;
  assign Radd_en      = en_q[2];
  assign Gadd_en      = en_q[1];
  assign Badd_en      = en_q[0];
  assign acc_clear    = acc_clear_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule
